// File: rtl/bank_mapper.sv
// +--------------------------------------------------------------------------+
// | bank_mapper : 16-bit CPU to PHYS_BITS physical memory bank mapper with    |
// |               boot-ROM overlay and external-RAM wait-state generator.     |
// | Option      : BANK_MAPPER_READBACK_EN enables I/O readback of registers.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module bank_mapper #(
    parameter int         PAGE_BITS    = 2,
    parameter int         PHYS_BITS    = 19,
    parameter logic [7:0] IO_BASE      = 8'hF0,
    parameter logic [7:0] ROM_OFF_PORT = 8'h38,
    parameter int         ROM_BITS     = 13,
    parameter int         WAIT_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [15:0]          cpu_addr,
    input  logic [7:0]           cpu_dout,
    input  logic                 n_mreq,
    input  logic                 n_iorq,
    input  logic                 n_rd,
    input  logic                 n_wr,
    output logic [PHYS_BITS-1:0] phys_addr,
    output logic                 n_rom_cs,
    output logic                 n_ram_cs,
    output logic                 rom_active,
    output logic                 wait_n,
    output logic [7:0]           map_dout,
    output logic                 map_sel
);

    localparam int         PW          = PHYS_BITS - 16 + PAGE_BITS;
    localparam int         NPAGES      = 1 << PAGE_BITS;
    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [PW-1:0]        r_page [NPAGES];
    logic                 r_rom_active;
    logic                 r_io_wr_d;
    state_t               r_state;
    logic [3:0]           r_cnt;
    logic                 r_wait_n;

    logic                 w_io_wr;
    logic                 w_wr_edge;
    logic [7:0]           w_page_off;
    logic                 w_page_hit;
    logic [PAGE_BITS-1:0] w_page_idx;
    logic                 w_rom_port;
    logic                 w_rom_sel;

    assign phys_addr  = {r_page[cpu_addr[15 -: PAGE_BITS]], cpu_addr[15-PAGE_BITS:0]};
    assign w_rom_sel  = !n_mreq && r_rom_active && (cpu_addr[15:ROM_BITS] == '0);
    assign n_rom_cs   = !w_rom_sel;
    assign n_ram_cs   = !(!n_mreq && n_rom_cs);
    assign rom_active = r_rom_active;
    assign wait_n     = r_wait_n;

    // Capture only on the first clock of an I/O write so a stretched strobe writes once.
    assign w_io_wr    = !n_iorq && !n_wr;
    assign w_wr_edge  = w_io_wr && !r_io_wr_d;
    assign w_page_off = cpu_addr[7:0] - IO_BASE;
    assign w_page_hit = (w_page_off < 8'(NPAGES));
    assign w_page_idx = w_page_off[PAGE_BITS-1:0];
    assign w_rom_port = (cpu_addr[7:0] == ROM_OFF_PORT);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NPAGES; i++) begin
                r_page[i] <= PW'(i);
            end
            r_rom_active <= 1'b1;
            r_io_wr_d    <= 1'b0;
        end else begin
            r_io_wr_d <= w_io_wr;
            if (w_wr_edge && w_page_hit) begin
                r_page[w_page_idx] <= cpu_dout[PW-1:0];
            end
            if (w_wr_edge && w_rom_port) begin
                r_rom_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_wait_n <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!n_ram_cs && (WAIT_CYCLES > 0)) begin
                        r_state  <= ST_WAIT;
                        r_cnt    <= C_WAIT_LOAD;
                        r_wait_n <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (n_mreq) begin
                        r_state  <= ST_IDLE;
                        r_wait_n <= 1'b1;
                    end else if (r_cnt == 4'd1) begin
                        r_state  <= ST_DONE;
                        r_wait_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (n_mreq) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_wait_n <= 1'b1;
                end
            endcase
        end
    end

`ifdef BANK_MAPPER_READBACK_EN
    logic w_io_rd;
    logic w_unused_bits;

    assign w_io_rd       = !n_iorq && !n_rd;
    assign w_unused_bits = &{1'b0, cpu_dout};

    always_comb begin
        map_sel  = 1'b0;
        map_dout = 8'hFF;
        if (w_io_rd && w_page_hit) begin
            map_sel  = 1'b1;
            map_dout = 8'(r_page[w_page_idx]);
        end else if (w_io_rd && w_rom_port) begin
            map_sel  = 1'b1;
            map_dout = {7'b0, r_rom_active};
        end
    end
`else
    logic w_unused_bits;

    assign w_unused_bits = &{1'b0, cpu_dout, n_rd};
    assign map_sel       = 1'b0;
    assign map_dout      = 8'hFF;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bank_mapper.sv
// Directed self-checking bench for bank_mapper (WAIT_CYCLES=3 build).
`default_nettype none

module tb_bank_mapper;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        n_mreq, n_iorq, n_rd, n_wr;
    logic [18:0] phys_addr;
    logic        n_rom_cs, n_ram_cs, rom_active, wait_n;
    logic [7:0]  map_dout;
    logic        map_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int lows;

    always #5 clk = ~clk;

    bank_mapper #(
        .PAGE_BITS   (2),
        .PHYS_BITS   (19),
        .IO_BASE     (8'hF0),
        .ROM_OFF_PORT(8'h38),
        .ROM_BITS    (13),
        .WAIT_CYCLES (3)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .n_mreq    (n_mreq),
        .n_iorq    (n_iorq),
        .n_rd      (n_rd),
        .n_wr      (n_wr),
        .phys_addr (phys_addr),
        .n_rom_cs  (n_rom_cs),
        .n_ram_cs  (n_ram_cs),
        .rom_active(rom_active),
        .wait_n    (wait_n),
        .map_dout  (map_dout),
        .map_sel   (map_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        tick();
        cpu_addr = {8'h00, port};
        cpu_dout = data;
        n_iorq   = 1'b0;
        n_wr     = 1'b0;
        tick();
        n_iorq   = 1'b1;
        n_wr     = 1'b1;
        tick();
    endtask

    task automatic phys_probe(input string tag, input logic [15:0] a, input logic [18:0] exp);
        cpu_addr = a;
        #1;
        check(tag, phys_addr, exp);
    endtask

    task automatic mem_probe(input string tag, input logic [15:0] a,
                             input logic exp_rom, input logic exp_ram);
        cpu_addr = a;
        n_mreq   = 1'b0;
        n_rd     = 1'b0;
        #1;
        check({tag, "_rom"}, n_rom_cs, exp_rom);
        check({tag, "_ram"}, n_ram_cs, exp_ram);
        n_mreq   = 1'b1;
        n_rd     = 1'b1;
        #1;
    endtask

    task automatic io_read_probe(input string tag, input logic [7:0] port,
                                 input logic exp_sel, input logic [7:0] exp_dout);
        cpu_addr = {8'h00, port};
        n_iorq   = 1'b0;
        n_rd     = 1'b0;
        #1;
        check({tag, "_sel"}, map_sel, exp_sel);
        check({tag, "_dout"}, map_dout, exp_dout);
        n_iorq   = 1'b1;
        n_rd     = 1'b1;
        #1;
    endtask

    initial begin
        n_reset  = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        n_mreq   = 1'b1;
        n_iorq   = 1'b1;
        n_rd     = 1'b1;
        n_wr     = 1'b1;
        tick();
        tick();
        check("rst_wait_n", wait_n, 1'b1);
        check("rst_rom_active", rom_active, 1'b1);
        n_reset = 1'b1;
        tick();

        // Identity map and ROM overlay out of reset
        phys_probe("id_4000", 16'h4000, 19'h04000);
        phys_probe("id_c123", 16'hC123, 19'h0C123);
        mem_probe("mem_4000", 16'h4000, 1'b1, 1'b0);
        mem_probe("mem_0100", 16'h0100, 1'b0, 1'b1);
        mem_probe("mem_1fff", 16'h1FFF, 1'b0, 1'b1);
        mem_probe("mem_2000", 16'h2000, 1'b1, 1'b0);
`ifdef BANK_MAPPER_READBACK_EN
        io_read_probe("rd_f2", 8'hF2, 1'b1, 8'h02);
`else
        io_read_probe("rd_f2", 8'hF2, 1'b0, 8'hFF);
`endif

        // Page register writes, upper data bits dropped
        io_write(8'hF1, 8'h1F);
        phys_probe("pg1_5678", 16'h5678, 19'h7D678);
        io_write(8'hF1, 8'hFF);
        phys_probe("pg1_ff", 16'h5678, 19'h7D678);
        phys_probe("pg0_keep", 16'h0123, 19'h00123);
        phys_probe("pg2_keep", 16'h8000, 19'h08000);
        phys_probe("pg3_keep", 16'hC123, 19'h0C123);

        // Unrelated ports change nothing
        io_write(8'h37, 8'h00);
        io_write(8'hF4, 8'h07);
        io_write(8'hEF, 8'h07);
        phys_probe("other_pg0", 16'h0123, 19'h00123);
        phys_probe("other_pg3", 16'hC123, 19'h0C123);
        check("other_rom", rom_active, 1'b1);

        // Stretched write with changing data captures only the first value
        tick();
        cpu_addr = 16'h00F0;
        cpu_dout = 8'h0A;
        n_iorq   = 1'b0;
        n_wr     = 1'b0;
        for (int i = 1; i < 5; i++) begin
            tick();
            cpu_dout = 8'h0A + 8'(i);
        end
        tick();
        n_iorq = 1'b1;
        n_wr   = 1'b1;
        tick();
        phys_probe("held_wr", 16'h0123, 19'h28123);

        // RAM read held 10 clocks: one 3-clock wait burst
        tick();
        cpu_addr = 16'h4000;
        n_mreq   = 1'b0;
        n_rd     = 1'b0;
        #1;
        check("wait_pre", wait_n, 1'b1);
        lows = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (!wait_n) lows++;
            check($sformatf("wait_c%0d", k), wait_n, (k <= 3) ? 1'b0 : 1'b1);
        end
        check("wait_burst", lows, 3);
        n_mreq = 1'b1;
        n_rd   = 1'b1;
        tick();
        tick();

        // ROM cycles never wait
        cpu_addr = 16'h0100;
        n_mreq   = 1'b0;
        n_rd     = 1'b0;
        lows = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (!wait_n) lows++;
        end
        check("rom_nowait", lows, 0);
        n_mreq = 1'b1;
        n_rd   = 1'b1;
        tick();

        // Boot ROM disable
        io_write(8'h38, 8'h5A);
        check("romoff_active", rom_active, 1'b0);
        mem_probe("romoff_0100", 16'h0100, 1'b1, 1'b0);
`ifdef BANK_MAPPER_READBACK_EN
        io_read_probe("rd_38", 8'h38, 1'b1, 8'h00);
`else
        io_read_probe("rd_38", 8'h38, 1'b0, 8'hFF);
`endif

        // Reset in the middle of a wait burst
        tick();
        cpu_addr = 16'h4000;
        n_mreq   = 1'b0;
        n_rd     = 1'b0;
        tick();
        check("midwait_low", wait_n, 1'b0);
        n_reset = 1'b0;
        #1;
        check("midwait_rst", wait_n, 1'b1);
        check("rerst_rom", rom_active, 1'b1);
        n_mreq = 1'b1;
        n_rd   = 1'b1;
        tick();
        n_reset = 1'b1;
        tick();
        phys_probe("rerst_pg0", 16'h0123, 19'h00123);
        phys_probe("rerst_pg1", 16'h4000, 19'h04000);
        mem_probe("rerst_0100", 16'h0100, 1'b0, 1'b1);
        check("rerst_wait_n", wait_n, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
